// File: rtl/qspi_tx_seq_if.sv
// -----------------------------------------------------------------------------
// qspi_tx_seq_if
// Upstream data-word stream feeding the QSPI transaction sequencer.
//   wdata  : 32-bit data word
//   wvalid : word valid (source -> sequencer)
//   wready : sequencer takes the word this cycle when wvalid & wready
// Modports: master = word source, slave = sequencer.
// -----------------------------------------------------------------------------
interface qspi_tx_seq_if;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;

  modport master (output wdata, output wvalid, input wready);
  modport slave  (input wdata, input wvalid, output wready);
endinterface

// File: rtl/qspi_tx_seq.sv
// -----------------------------------------------------------------------------
// qspi_tx_seq
// Sequences one quad-lane QSPI write: CMD (2 nibbles), optional ADDR (6/8
// nibbles), DUMMY cycles, then len 32-bit words (8 nibbles each), driving a
// 32-bit load/shift nibble transmitter that samples t_load/t_enb on the
// falling edge and shows the selected nibble on its pins one cycle later.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  begin a transaction (only seen in IDLE)
//   cmd_i, addr_en_i,
//   addr4b_i, addr_i,
//   dummy_i, len_i,
//   lsb_cfg_i                transaction config, latched on accepted start
//   wr                       data-word stream (slave side)
//   p_data_o, t_load_o,
//   t_enb_o, lsb_o           transmitter controls
//   cs_no                    flash chip select, active-low
//   sclk_en_o, oe_o          flash clock / lane enable, aligned to the pins
//   busy_o, done_o           status
// -----------------------------------------------------------------------------
module qspi_tx_seq #(
  parameter int LEN_W   = 8,
  parameter int DUMMY_W = 5,
  parameter int CS_IDLE = 2   // must be >= 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [7:0]         cmd_i,
  input  logic               addr_en_i,
  input  logic               addr4b_i,
  input  logic [31:0]        addr_i,
  input  logic [DUMMY_W-1:0] dummy_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               lsb_cfg_i,
  qspi_tx_seq_if.slave       wr,
  output logic [31:0]        p_data_o,
  output logic               t_load_o,
  output logic               t_enb_o,
  output logic               lsb_o,
  output logic               cs_no,
  output logic               sclk_en_o,
  output logic               oe_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_FLUSH, S_CSHOLD
  } state_e;

  typedef struct packed {
    logic [7:0]         cmd;
    logic               addr_en;
    logic               addr4b;
    logic [31:0]        addr;
    logic [DUMMY_W-1:0] dummy;
    logic               lsb;
  } cfg_t;

  // One shared counter: nibble index within a phase, dummy cycles, CS hold.
  localparam int HOLD_W = $clog2(CS_IDLE + 1);
  localparam int CNT_W  = (DUMMY_W > 3) ? ((DUMMY_W > HOLD_W) ? DUMMY_W : HOLD_W)
                                        : ((HOLD_W > 3) ? HOLD_W : 3);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   words_q, words_d;   // words still to be loaded
  cfg_t               cfg_q, cfg_d;
  logic               sclk_en_q, sclk_en_d;
  logic               oe_q, oe_d;
  logic               cs_n_q, cs_n_d;
  logic               done_q, done_d;

  state_e             after_cmd, after_addr, after_dummy;
  logic [CNT_W-1:0]   addr_last;
  logic               dummy_cycle;

  // Phase skipping: each optional phase falls through to the next one present.
  assign after_dummy = (words_q != '0)         ? S_DATA  : S_FLUSH;
  assign after_addr  = (cfg_q.dummy != '0)     ? S_DUMMY : after_dummy;
  assign after_cmd   = cfg_q.addr_en           ? S_ADDR  : after_addr;
  assign addr_last   = cfg_q.addr4b ? CNT_W'(7) : CNT_W'(5);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      words_q   <= '0;
      cfg_q     <= '0;
      sclk_en_q <= 1'b0;
      oe_q      <= 1'b0;
      cs_n_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      words_q   <= words_d;
      cfg_q     <= cfg_d;
      sclk_en_q <= sclk_en_d;
      oe_q      <= oe_d;
      cs_n_q    <= cs_n_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first, so no path through
  // the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    cfg_d   = cfg_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d       = S_CMD;
          cnt_d         = '0;
          words_d       = len_i;
          cfg_d.cmd     = cmd_i;
          cfg_d.addr_en = addr_en_i;
          cfg_d.addr4b  = addr4b_i;
          cfg_d.addr    = addr_i;
          cfg_d.dummy   = dummy_i;
          cfg_d.lsb     = lsb_cfg_i;
        end
      end
      S_CMD: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = after_cmd;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ADDR: begin
        if (cnt_q == addr_last) begin
          state_d = after_addr;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DUMMY: begin
        if (cnt_q == CNT_W'(cfg_q.dummy) - CNT_W'(1)) begin
          state_d = after_dummy;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        // cnt_q == 0 is the load-due slot; it holds there while the source
        // underruns, so the stall costs cycles but never a nibble.
        if (cnt_q == '0) begin
          if (wr.wvalid) begin
            cnt_d   = CNT_W'(1);
            words_d = words_q - 1'b1;
          end
        end else if (cnt_q == CNT_W'(7)) begin
          cnt_d = '0;
          if (words_q == '0) state_d = S_FLUSH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FLUSH: begin
        state_d = S_CSHOLD;
        cnt_d   = '0;
      end
      S_CSHOLD: begin
        if (cnt_q == CNT_W'(CS_IDLE - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    t_load_o    = 1'b0;
    t_enb_o     = 1'b0;
    p_data_o    = '0;
    wr.wready   = 1'b0;
    dummy_cycle = 1'b0;

    unique case (state_q)
      S_CMD: begin
        if (cnt_q == '0) begin
          t_load_o = 1'b1;
          p_data_o = cfg_q.lsb ? {24'h0, cfg_q.cmd} : {cfg_q.cmd, 24'h0};
        end else begin
          t_enb_o = 1'b1;
        end
      end
      S_ADDR: begin
        if (cnt_q == '0) begin
          t_load_o = 1'b1;
          if (cfg_q.addr4b)   p_data_o = cfg_q.addr;
          else if (cfg_q.lsb) p_data_o = {8'h0, cfg_q.addr[23:0]};
          else                p_data_o = {cfg_q.addr[23:0], 8'h0};
        end else begin
          t_enb_o = 1'b1;
        end
      end
      S_DUMMY: dummy_cycle = 1'b1;
      S_DATA: begin
        if (cnt_q == '0) begin
          wr.wready = 1'b1;
          if (wr.wvalid) begin
            t_load_o = 1'b1;
            p_data_o = wr.wdata;
          end
        end else begin
          t_enb_o = 1'b1;
        end
      end
      default: ;
    endcase

    // Registered one cycle so they line up with the nibble on the pins.
    sclk_en_d = t_load_o | t_enb_o | dummy_cycle;
    oe_d      = t_load_o | t_enb_o;
    cs_n_d    = (state_d == S_IDLE) || (state_d == S_CSHOLD);
  end

  assign sclk_en_o = sclk_en_q;
  assign oe_o      = oe_q;
  assign cs_no     = cs_n_q;
  assign done_o    = done_q;
  assign busy_o    = (state_q != S_IDLE);
  assign lsb_o     = cfg_q.lsb;

endmodule

// File: tb/tb_qspi_tx_seq.sv
// -----------------------------------------------------------------------------
// tb_qspi_tx_seq
// Self-checking bench for qspi_tx_seq. The expected transaction is a queue of
// clocked flash cycles (lane nibble or dummy) built from the command, address
// and data words; a simple transmitter model turns t_load/t_enb/p_data into pin
// nibbles, and every sclk_en_o cycle is matched against the queue.
// -----------------------------------------------------------------------------
module tb_qspi_tx_seq;
  localparam int LEN_W   = 8;
  localparam int DUMMY_W = 5;
  localparam int CS_IDLE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               start_i = 1'b0;
  logic [7:0]         cmd_i = '0;
  logic               addr_en_i = 1'b0, addr4b_i = 1'b0, lsb_cfg_i = 1'b0;
  logic [31:0]        addr_i = '0;
  logic [DUMMY_W-1:0] dummy_i = '0;
  logic [LEN_W-1:0]   len_i = '0;
  logic [31:0]        p_data;
  logic               t_load, t_enb, lsb, cs_n, sclk_en, oe, busy, done;

  qspi_tx_seq_if wr_if ();

  qspi_tx_seq #(.LEN_W(LEN_W), .DUMMY_W(DUMMY_W), .CS_IDLE(CS_IDLE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .cmd_i(cmd_i),
    .addr_en_i(addr_en_i), .addr4b_i(addr4b_i), .addr_i(addr_i),
    .dummy_i(dummy_i), .len_i(len_i), .lsb_cfg_i(lsb_cfg_i), .wr(wr_if),
    .p_data_o(p_data), .t_load_o(t_load), .t_enb_o(t_enb), .lsb_o(lsb),
    .cs_no(cs_n), .sclk_en_o(sclk_en), .oe_o(oe), .busy_o(busy), .done_o(done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected flash cycles: bit4 = lanes driven (nibble), bit4 = 0 -> dummy.
  logic [4:0]  exp_q[$];
  logic [31:0] src_q[$];
  logic [31:0] tx_sr = '0;
  logic [3:0]  tx_pin = '0;
  logic [63:0] got_nibs;
  logic        cur_lsb = 1'b0;
  logic        prev_cs = 1'b1;
  int cyc = 0, n_sclk, n_nib, first_sclk, last_sclk, n_hs, n_und, n_wr, n_done;
  int cs_run = 100;
  int stall_word = -1, stall_left = 0;
  bit rand_mode = 1'b0;

  task automatic push_val(input logic [31:0] v, input int n, input bit lb);
    for (int i = 0; i < n; i++) begin
      int sh;
      sh = lb ? 4 * i : 4 * (n - 1 - i);
      exp_q.push_back({1'b1, 4'(v >> sh)});
    end
  endtask

  // Monitor: compares on the falling edge, then advances the transmitter model.
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        cyc++;
        if (sclk_en) begin
          n_sclk++;
          if (first_sclk < 0) first_sclk = cyc;
          last_sclk = cyc;
          if (exp_q.size() == 0) check("extra_sclk_cycle", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("oe_vs_model", oe, e[4]);
            if (e[4]) begin
              check("pin_nibble", tx_pin, e[3:0]);
              got_nibs = {got_nibs[59:0], tx_pin};
              n_nib++;
            end
          end
          check("cs_low_while_clocking", cs_n, 0);
        end else begin
          check("oe_without_sclk", oe, 0);
        end
        check("load_enb_exclusive", t_load & t_enb, 0);
        if (busy) check("lsb_o", lsb, cur_lsb);
        if (!cs_n) check("busy_while_cs_low", busy, 1);
        if (done) n_done++;
        if (cs_n) cs_run++;
        else begin
          if (prev_cs) check("cs_high_at_least_cs_idle", (cs_run >= CS_IDLE), 1);
          cs_run = 0;
        end
        prev_cs = cs_n;
        if (wr_if.wready) n_wr++;
        if (wr_if.wready && !wr_if.wvalid) n_und++;
        if (wr_if.wready && wr_if.wvalid) begin
          n_hs++;
          if (src_q.size() > 0) void'(src_q.pop_front());
        end
        if (t_load) begin
          tx_sr  = p_data;
          tx_pin = lsb ? tx_sr[3:0] : tx_sr[31:28];
        end else if (t_enb) begin
          tx_sr  = lsb ? (tx_sr >> 4) : (tx_sr << 4);
          tx_pin = lsb ? tx_sr[3:0] : tx_sr[31:28];
        end
      end
    end
  end

  // Word source: presents the head of src_q, with directed or random drops.
  initial begin
    wr_if.wvalid = 1'b0;
    wr_if.wdata  = '0;
    forever begin
      bit give;
      @(posedge clk);
      #1;
      give = (src_q.size() > 0);
      if (give && wr_if.wready && n_hs == stall_word && stall_left > 0) begin
        give = 1'b0;
        stall_left--;
      end
      if (give && rand_mode && $urandom_range(3) == 0) give = 1'b0;
      wr_if.wvalid = rst_n && give;
      wr_if.wdata  = give ? src_q[0] : $urandom;
    end
  end

  int cur_len, cur_a, cur_dummy;

  task automatic setup_txn(input logic [7:0] c, input bit ae, input bit a4,
                           input logic [31:0] a, input int d, input int l,
                           input bit lb, input logic [31:0] w0,
                           input int sw, input int sc);
    logic [31:0] w;
    exp_q.delete();
    src_q.delete();
    push_val({24'h0, c}, 2, lb);
    cur_a = 0;
    if (ae) begin
      cur_a = a4 ? 8 : 6;
      push_val(a4 ? a : {8'h0, a[23:0]}, cur_a, lb);
    end
    for (int i = 0; i < d; i++) exp_q.push_back(5'h00);
    for (int i = 0; i < l; i++) begin
      w = (i == 0) ? w0 : $urandom;
      src_q.push_back(w);
      push_val(w, 8, lb);
    end
    cur_len = l; cur_dummy = d; cur_lsb = lb;
    n_sclk = 0; n_nib = 0; first_sclk = -1; last_sclk = -1;
    n_hs = 0; n_und = 0; n_wr = 0; n_done = 0; got_nibs = '0;
    stall_word = sw; stall_left = sc;
    cmd_i = c; addr_en_i = ae; addr4b_i = a4; addr_i = a;
    dummy_i = DUMMY_W'(d); len_i = LEN_W'(l); lsb_cfg_i = lb;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    // Config changes after acceptance must have no effect.
    cmd_i = $urandom; addr_en_i = $urandom; addr4b_i = $urandom; addr_i = $urandom;
    dummy_i = $urandom; len_i = $urandom; lsb_cfg_i = $urandom;
  endtask

  task automatic finish_txn(input bit busy_start);
    bit seen;
    if (busy_start) begin
      repeat (3) begin @(posedge clk); #1; end
      start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("done_within_budget", seen, 1);
    @(negedge clk); #1;
    check("stream_consumed", exp_q.size(), 0);
    check("sclk_count", n_sclk, 2 + cur_a + cur_dummy + 8 * cur_len);
    check("handshakes", n_hs, cur_len);
    check("done_pulses", n_done, 1);
    check("gaps_equal_underruns", last_sclk - first_sclk + 1 - n_sclk, n_und);
    check("busy_after_done", busy, 0);
    if (cur_len == 0) check("no_wready_without_data", n_wr, 0);
  endtask

  initial begin
    bit seen;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk_en", sclk_en, 0);
    check("rst_oe", oe, 0);
    check("rst_t_load", t_load, 0);
    check("rst_t_enb", t_enb, 0);
    check("rst_wready", wr_if.wready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_p_data", p_data, 0);
    check("rst_lsb", lsb, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // MSB-first write with 24-bit address
    setup_txn(8'h32, 1, 0, 32'h00123456, 0, 1, 0, 32'hDEADBEEF, -1, 0);
    finish_txn(0);
    check("t1_nibbles", got_nibs, 64'h32123456DEADBEEF);
    check("t1_sclk_16", n_sclk, 16);

    // Same, LSB-first (started back-to-back with the previous done)
    setup_txn(8'h32, 1, 0, 32'h00123456, 0, 1, 1, 32'hDEADBEEF, -1, 0);
    finish_txn(0);
    check("t2_nibbles", got_nibs, 64'h23654321FEEBDAED);

    // 32-bit address, 8 dummy cycles, no data
    setup_txn(8'h6B, 1, 1, 32'hA1B2C3D4, 8, 0, 0, 32'h0, -1, 0);
    finish_txn(0);
    check("t3_sclk_18", n_sclk, 18);
    check("t3_lane_nibbles_10", n_nib, 10);
    check("t3_nibbles", got_nibs, 64'h0000006BA1B2C3D4);
    check("t3_wready_cycles", n_wr, 0);

    // Three words, source drops for 5 due cycles before word 2, start while busy
    setup_txn(8'h38, 0, 0, 32'h0, 0, 3, 0, 32'h01234567, 1, 5);
    finish_txn(1);
    check("t4_lane_nibbles_26", n_nib, 26);
    check("t4_handshakes_3", n_hs, 3);
    check("t4_underrun_5", n_und, 5);
    check("t4_gap_5", last_sclk - first_sclk + 1 - n_sclk, 5);
    repeat (4) begin @(posedge clk); #1; end
    check("t4_no_restart_busy", busy, 0);
    check("t4_no_restart_cs", cs_n, 1);

    // Reset in the middle of DATA
    setup_txn(8'h32, 1, 0, 32'h00ABCDEF, 2, 4, 0, 32'hCAFEF00D, -1, 0);
    seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (n_hs >= 2) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("reach_data_phase", seen, 1);
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", cs_n, 1);
    check("abort_t_load", t_load, 0);
    check("abort_t_enb", t_enb, 0);
    check("abort_wready", wr_if.wready, 0);
    check("abort_sclk_en", sclk_en, 0);
    check("abort_busy", busy, 0);
    exp_q.delete();
    src_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cs_run = 100; prev_cs = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    setup_txn(8'hA5, 1, 1, 32'h89ABCDEF, 3, 2, 1, 32'h13579BDF, -1, 0);
    finish_txn(0);

    // Randomized transactions with random source underruns
    rand_mode = 1'b1;
    for (int t = 0; t < 12; t++) begin
      setup_txn(8'($urandom), 1'($urandom), 1'($urandom), $urandom,
                int'($urandom_range(7)), int'($urandom_range(4)), 1'($urandom),
                $urandom, -1, 0);
      finish_txn(t % 4 == 1);
    end
    rand_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
